// File: rtl/mem_block_xfer.sv
// mem_block_xfer: moves one cache block between the cache controller and a
// word-wide main memory, one word per memory access-complete pulse.
//   fill       : memory -> o_rd_block
//   write-back : i_wr_block -> memory
// Optional feature macro: CRITICAL_WORD_FIRST_EN (fills start at the requested
// word and wrap around; the first captured word is also reported on o_crit_word).
module mem_block_xfer #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 64,
    parameter int BLOCK_WORDS = 16
) (
    input  logic                              i_clk,
    input  logic                              i_arst,
    input  logic                              i_start_read,
    input  logic                              i_start_write,
    input  logic [ADDR_WIDTH-1:0]             i_addr,
    input  logic [BLOCK_WORDS*DATA_WIDTH-1:0] i_wr_block,
    output logic [BLOCK_WORDS*DATA_WIDTH-1:0] o_rd_block,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_crit_valid,
    output logic [DATA_WIDTH-1:0]             o_crit_word,
    output logic [ADDR_WIDTH-1:0]             o_mem_addr,
    output logic [DATA_WIDTH-1:0]             o_mem_data,
    output logic                              o_mem_write_en,
    input  logic [DATA_WIDTH-1:0]             i_mem_read_data,
    input  logic                              i_mem_access
);

    localparam int OFF = $clog2(BLOCK_WORDS);
    localparam int BW  = ADDR_WIDTH - OFF - 2;   // block-number bits of the address
    localparam logic [OFF:0] CNT_LAST = (OFF+1)'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                                    state_q, state_d;
    logic [BW-1:0]                             base_q, base_d;
    logic [OFF-1:0]                            st_q, st_d;
    logic [OFF:0]                              cnt_q, cnt_d;
    logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0]    wr_block_q, wr_block_d;
    logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0]    rd_block_q, rd_block_d;
    logic [OFF-1:0]                            idx;
    logic [OFF-1:0]                            start_st;

    // Word index wraps inside the block; no carry ever reaches the base.
    assign idx = st_q + cnt_q[OFF-1:0];

`ifdef CRITICAL_WORD_FIRST_EN
    logic                  crit_valid_q, crit_valid_d;
    logic [DATA_WIDTH-1:0] crit_word_q, crit_word_d;
    logic                  unused_addr_lsb;

    // Fills begin at the requested word; write-backs always begin at word 0.
    assign start_st        = i_start_write ? '0 : i_addr[OFF+1:2];
    assign unused_addr_lsb = ^i_addr[1:0];
    assign o_crit_valid    = crit_valid_q;
    assign o_crit_word     = crit_word_q;
`else
    logic unused_addr_lsb;

    // Without critical-word-first every transfer walks the block from word 0.
    assign start_st        = '0;
    assign unused_addr_lsb = ^i_addr[OFF+1:0];
    assign o_crit_valid    = 1'b0;
    assign o_crit_word     = '0;
`endif

    // State and datapath registers; reset aborts any transfer immediately.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            st_q       <= '0;
            cnt_q      <= '0;
            wr_block_q <= '0;
            rd_block_q <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
            crit_valid_q <= 1'b0;
            crit_word_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            st_q       <= st_d;
            cnt_q      <= cnt_d;
            wr_block_q <= wr_block_d;
            rd_block_q <= rd_block_d;
`ifdef CRITICAL_WORD_FIRST_EN
            crit_valid_q <= crit_valid_d;
            crit_word_q  <= crit_word_d;
`endif
        end
    end

    // Next-state logic: start acceptance, word stepping on each access pulse.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        st_d       = st_q;
        cnt_d      = cnt_q;
        wr_block_d = wr_block_q;
        rd_block_d = rd_block_q;
`ifdef CRITICAL_WORD_FIRST_EN
        crit_valid_d = 1'b0;
        crit_word_d  = crit_word_q;
`endif
        case (state_q)
            S_IDLE: begin
                // Write-back wins a simultaneous request; the read is dropped.
                if (i_start_write || i_start_read) begin
                    state_d = i_start_write ? S_WRITE : S_READ;
                    base_d  = i_addr[ADDR_WIDTH-1:OFF+2];
                    st_d    = start_st;
                    cnt_d   = '0;
                    if (i_start_write) begin
                        wr_block_d = i_wr_block;
                    end
                end
            end
            S_READ: begin
                if (i_mem_access) begin
                    rd_block_d[idx] = i_mem_read_data;
                    cnt_d           = cnt_q + 1'b1;
`ifdef CRITICAL_WORD_FIRST_EN
                    if (cnt_q == '0) begin
                        crit_word_d  = i_mem_read_data;
                        crit_valid_d = 1'b1;
                    end
`endif
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_WRITE: begin
                if (i_mem_access) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Memory-side outputs come straight from registers so they stay stable
    // for as long as the memory takes to respond.
    assign o_busy         = (state_q != S_IDLE);
    assign o_done         = (state_q == S_DONE);
    assign o_mem_write_en = (state_q == S_WRITE);
    assign o_mem_addr     = {base_q, idx, 2'b00};
    assign o_mem_data     = (state_q == S_WRITE) ? wr_block_q[idx] : '0;
    assign o_rd_block     = rd_block_q;

endmodule

// File: tb/tb_mem_block_xfer.sv
// Self-checking bench for mem_block_xfer: a word-array memory answering every
// Nth cycle, randomized transfers, and a reference of expected address order
// and block contents computed from the block/offset arithmetic.
module tb_mem_block_xfer;

    localparam int DW = 32;
    localparam int AW = 64;
    localparam int BWORDS = 16;

    logic                   i_clk = 1'b0;
    logic                   i_arst = 1'b1;
    logic                   i_start_read = 1'b0;
    logic                   i_start_write = 1'b0;
    logic [AW-1:0]          i_addr = '0;
    logic [BWORDS*DW-1:0]   i_wr_block = '0;
    logic [BWORDS*DW-1:0]   o_rd_block;
    logic                   o_busy, o_done, o_crit_valid, o_mem_write_en;
    logic [DW-1:0]          o_crit_word, o_mem_data;
    logic [AW-1:0]          o_mem_addr;
    logic [DW-1:0]          i_mem_read_data = '0;
    logic                   i_mem_access = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem [logic [61:0]];
    logic [63:0] addr_log [$];

    mem_block_xfer dut (
        .i_clk(i_clk), .i_arst(i_arst),
        .i_start_read(i_start_read), .i_start_write(i_start_write),
        .i_addr(i_addr), .i_wr_block(i_wr_block), .o_rd_block(o_rd_block),
        .o_busy(o_busy), .o_done(o_done),
        .o_crit_valid(o_crit_valid), .o_crit_word(o_crit_word),
        .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data), .o_mem_write_en(o_mem_write_en),
        .i_mem_read_data(i_mem_read_data), .i_mem_access(i_mem_access)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rdmem(input logic [63:0] a);
        return mem.exists(a[63:2]) ? mem[a[63:2]] : 32'h0;
    endfunction

    // One complete transfer with the memory answering every n-th cycle.
    task automatic xfer(input bit wr, input bit rd, input logic [63:0] addr,
                        input logic [BWORDS*DW-1:0] blk, input int n,
                        input bit inject, input string tag);
        logic [63:0] base;
        int st, ph, cyc, done_cnt, acc_cnt, we_bad, crit_cnt;
        logic [31:0] crit_w;
        base = {addr[63:6], 6'b0};
        st = 0;
`ifdef CRITICAL_WORD_FIRST_EN
        if (!wr) st = int'(addr[5:2]);
`endif
        addr_log.delete();
        ph = 0; cyc = 0; done_cnt = 0; acc_cnt = 0; we_bad = 0; crit_cnt = 0; crit_w = '0;
        @(negedge i_clk);
        i_start_write = wr; i_start_read = rd; i_addr = addr; i_wr_block = blk;
        @(negedge i_clk);
        i_start_write = 1'b0; i_start_read = 1'b0;
        while (done_cnt == 0 && cyc < 2000) begin
            i_start_read = inject && (cyc == 5);
            if (o_crit_valid) begin crit_cnt++; crit_w = o_crit_word; end
            ph++;
            i_mem_access = (ph % n == 0);
            i_mem_read_data = $urandom;
            if (o_done) begin
                done_cnt++;
            end else if (o_busy) begin
                if (o_mem_write_en !== wr) we_bad++;
                if (i_mem_access) begin
                    acc_cnt++;
                    addr_log.push_back(o_mem_addr);
                    if (o_mem_write_en) mem[o_mem_addr[63:2]] = o_mem_data;
                    else i_mem_read_data = rdmem(o_mem_addr);
                end
            end
            @(negedge i_clk);
            cyc++;
        end
        i_mem_access = 1'b0;
        i_start_read = 1'b0;
        chk({tag, "_done"}, 64'(done_cnt), 64'd1);
        chk({tag, "_accesses"}, 64'(acc_cnt), 64'd16);
        chk({tag, "_we_level"}, 64'(we_bad), 64'd0);
        chk({tag, "_busy_after"}, 64'(o_busy), 64'd0);
        for (int k = 0; k < BWORDS; k++) begin
            if (k < addr_log.size())
                chk($sformatf("%s_addr%0d", tag, k), addr_log[k], base + 64'(((st + k) % BWORDS) * 4));
            else
                chk($sformatf("%s_addr%0d_missing", tag, k), 64'd0, 64'd1);
            if (wr)
                chk($sformatf("%s_memword%0d", tag, k), 64'(rdmem(base + 64'(k * 4))), 64'(blk[k*DW +: DW]));
            else
                chk($sformatf("%s_rdword%0d", tag, k), 64'(o_rd_block[k*DW +: DW]), 64'(rdmem(base + 64'(k * 4))));
        end
`ifdef CRITICAL_WORD_FIRST_EN
        if (!wr) begin
            chk({tag, "_crit_pulses"}, 64'(crit_cnt), 64'd1);
            chk({tag, "_crit_word"}, 64'(crit_w), 64'(rdmem(base + 64'(st * 4))));
        end
`else
        chk({tag, "_crit_pulses"}, 64'(crit_cnt), 64'd0);
`endif
        // No stray second transfer (e.g. a dropped or mid-transfer read).
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            chk({tag, "_quiet"}, {62'd0, o_busy, o_done}, 64'd0);
        end
    endtask

    initial begin
        logic [BWORDS*DW-1:0] blk;
        int acc;
        // 1: reset state
        #1;
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_we", 64'(o_mem_write_en), 64'd0);
        chk("rst_rd_block", 64'(|o_rd_block), 64'd0);
        chk("rst_mem_addr", o_mem_addr, 64'd0);
        repeat (3) @(negedge i_clk);
        i_arst = 1'b0;

        // 2: write-back of 0xA0..0xAF from an unaligned address
        for (int k = 0; k < BWORDS; k++) blk[k*DW +: DW] = 32'hA0 + 32'(k);
        xfer(1'b1, 1'b0, 64'h104, blk, 3, 1'b0, "wr_a0");

        // 3: fill the same block back
        xfer(1'b0, 1'b1, 64'h100, '0, 2, 1'b0, "rd_a0");
        for (int k = 0; k < BWORDS; k++)
            chk($sformatf("rd_a0_lit%0d", k), 64'(o_rd_block[k*DW +: DW]), 64'h0A0 + 64'(k));

        // 5: critical-word order (sequential when the feature is off)
        xfer(1'b0, 1'b1, 64'h128, '0, 1, 1'b0, "rd_crit");

        // 4: simultaneous starts -> write, read pulsed mid-transfer ignored
        for (int k = 0; k < BWORDS; k++) blk[k*DW +: DW] = $urandom;
        xfer(1'b1, 1'b1, 64'h200, blk, 2, 1'b1, "both");

        // 6: reset after five written words
        @(negedge i_clk);
        i_start_write = 1'b1; i_addr = 64'h300; i_wr_block = blk;
        @(negedge i_clk);
        i_start_write = 1'b0;
        acc = 0;
        for (int c = 0; c < 200 && acc < 5; c++) begin
            i_mem_access = (c % 2 == 1);
            if (i_mem_access && o_mem_write_en) acc++;
            @(negedge i_clk);
        end
        i_mem_access = 1'b0;
        chk("abort_acc_seen", 64'(acc), 64'd5);
        i_arst = 1'b1;
        #1;
        chk("abort_busy", 64'(o_busy), 64'd0);
        chk("abort_we", 64'(o_mem_write_en), 64'd0);
        chk("abort_done", 64'(o_done), 64'd0);
        @(negedge i_clk);
        i_arst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge i_clk);
            chk("abort_quiet", {62'd0, o_busy, o_done}, 64'd0);
        end
        xfer(1'b1, 1'b0, 64'h300, blk, 1, 1'b0, "after_rst");

        // Randomized write/read pairs over a few blocks
        for (int t = 0; t < 6; t++) begin
            logic [63:0] a;
            a = 64'h1000 + 64'($urandom_range(0, 3) * 64) + 64'($urandom_range(0, 15) * 4);
            for (int k = 0; k < BWORDS; k++) blk[k*DW +: DW] = $urandom;
            xfer(1'b1, 1'b0, a, blk, int'($urandom_range(1, 4)), 1'b0, $sformatf("rnd_wr%0d", t));
            a = {a[63:6], 4'($urandom_range(0, 15)), 2'b00};
            xfer(1'b0, 1'b1, a, '0, int'($urandom_range(1, 4)), 1'b0, $sformatf("rnd_rd%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
